// File: rtl/plot_scheduler.sv
// Three-requester rectangle fill scheduler: round-robin arbitration, then a
// row-major pixel scan to a VGA adapter with clipping to the visible area.
module plot_scheduler #(
  parameter int unsigned XW   = 8,
  parameter int unsigned YW   = 7,
  parameter int unsigned CW   = 3,
  parameter int unsigned XMAX = 160,
  parameter int unsigned YMAX = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [3*XW-1:0]   req_x,
  input  logic [3*YW-1:0]   req_y,
  input  logic [11:0]       req_w,
  input  logic [11:0]       req_h,
  input  logic [3*CW-1:0]   req_color,
  output logic [2:0]        done,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic [CW-1:0]     color,
  output logic              plot,
  output logic              busy
);

  localparam int unsigned SXW = XW + 1;
  localparam int unsigned SYW = YW + 1;
  localparam int unsigned DW  = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [XW-1:0]   x0_q, x0_d;
  logic [YW-1:0]   y0_q, y0_d;
  logic [DW-1:0]   w_q, w_d;
  logic [DW-1:0]   h_q, h_d;
  logic [CW-1:0]   col_q, col_d;
  logic [DW-1:0]   cx_q, cx_d;
  logic [DW-1:0]   cy_q, cy_d;
  logic [2:0]      ready_q, ready_d;
  logic [2:0]      done_q, done_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   color_q, color_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;

  logic [1:0]      gnt_c;
  logic            gnt_ok_c;
  logic [SXW-1:0]  sum_x_c;
  logic [SYW-1:0]  sum_y_c;
  logic [DW-1:0]   sel_w_c;
  logic [DW-1:0]   sel_h_c;

  assign sum_x_c = SXW'(x0_q) + SXW'(cx_q);
  assign sum_y_c = SYW'(y0_q) + SYW'(cy_q);
  assign sel_w_c = req_w[32'(gnt_c)*DW +: DW];
  assign sel_h_c = req_h[32'(gnt_c)*DW +: DW];

  // Round-robin pick: first valid requester at or after ptr, wrapping 2->0.
  always_comb begin
    gnt_ok_c = |req_valid;
    gnt_c    = 2'd0;
    case (ptr_q)
      2'd1:    gnt_c = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
      2'd2:    gnt_c = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
      default: gnt_c = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ready_d = 3'b000;
    done_d  = 3'b000;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_ok_c) begin
          ready_d = 3'b001 << gnt_c;
          gnt_d   = gnt_c;
          x0_d    = req_x[32'(gnt_c)*XW +: XW];
          y0_d    = req_y[32'(gnt_c)*YW +: YW];
          col_d   = req_color[32'(gnt_c)*CW +: CW];
          w_d     = sel_w_c;
          h_d     = sel_h_c;
          cx_d    = '0;
          cy_d    = '0;
          state_d = (sel_w_c != '0 && sel_h_c != '0) ? ST_DRAW : ST_DONE;
        end
      end
      ST_DRAW: begin
        // Clipped pixels still take their cycle, only the write enable drops.
        plot_d  = (sum_x_c < SXW'(XMAX)) && (sum_y_c < SYW'(YMAX));
        x_d     = sum_x_c[XW-1:0];
        y_d     = sum_y_c[YW-1:0];
        color_d = col_q;
        if (cx_q == w_q - 4'd1) begin
          cx_d = '0;
          if (cy_q == h_q - 4'd1) begin
            state_d = ST_DONE;
          end else begin
            cy_d = cy_q + 4'd1;
          end
        end else begin
          cx_d = cx_q + 4'd1;
        end
      end
      ST_DONE: begin
        done_d  = 3'b001 << gnt_q;
        ptr_d   = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ready_q <= '0;
      done_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign x         = x_q;
  assign y         = y_q;
  assign color     = color_q;
  assign plot      = plot_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Scoreboard bench for plot_scheduler: stimulus queues expected ready/plot/done
// events with cycle offsets from the accept; a forked monitor pops and compares.
module tb_plot_scheduler;

  localparam int KR = 0;
  localparam int KP = 1;
  localparam int KD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [11:0] req_w;
  logic [11:0] req_h;
  logic [8:0]  req_color;
  logic [2:0]  done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        plot;
  logic        busy;

  plot_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .req_color(req_color), .done(done), .x(x), .y(y), .color(color),
    .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    int dt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   t_acc = 0;

  function automatic void ex(input int k, input int a, input int b, input int c, input int dt);
    exp_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c; e.dt = dt;
    sb.push_back(e);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Pop one expected event and compare kind, fields and offset from last accept.
  task automatic take(input int k, input int a, input int b, input int c);
    exp_t e;
    int   dt;
    dt = cyc - t_acc;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d c=%0d at cycle %0d, required none",
               k, a, b, c, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.a != a || (k == KP && (e.b != b || e.c != c)) ||
          (e.dt >= 0 && e.dt != dt)) begin
        n_bad++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d dt=%0d, required kind=%0d a=%0d b=%0d c=%0d dt=%0d",
                 k, a, b, c, dt, e.kind, e.a, e.b, e.c, e.dt);
      end
    end
    if (k == KR) t_acc = cyc;
  endtask

  function automatic int dec(input logic [2:0] v);
    if ($countones(v) != 1) return -1;
    return v[0] ? 0 : (v[1] ? 1 : 2);
  endfunction

  task automatic monitor();
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (req_ready != 3'b000) take(KR, dec(req_ready), 0, 0);
      if (plot) take(KP, int'(x), int'(y), int'(color));
      if (done != 3'b000) take(KD, dec(done), 0, 0);
    end
  endtask

  task automatic send(input int id, input int px, input int py, input int pw,
                      input int ph, input int pc);
    bit got;
    got = 1'b0;
    req_x[id*8 +: 8]     = 8'(px);
    req_y[id*7 +: 7]     = 7'(py);
    req_w[id*4 +: 4]     = 4'(pw);
    req_h[id*4 +: 4]     = 4'(ph);
    req_color[id*3 +: 3] = 3'(pc);
    req_valid[id]        = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_req%0d: ready never seen, required within 200 cycles", id);
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_check(input string nm, input int ex_x, input int ex_y, input int ex_c);
    wait_idle();
    chk({nm, "_x"}, int'(x), ex_x);
    chk({nm, "_y"}, int'(y), ex_y);
    chk({nm, "_color"}, int'(color), ex_c);
    chk({nm, "_quiet"}, int'({plot, busy, req_ready, done}), 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_w     = '0;
    req_h     = '0;
    req_color = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", int'({plot, busy, req_ready, done}), 0);
    chk("reset_xy", int'({x, y}), 0);
    chk("reset_color", int'(color), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Zero-width command: done one cycle after accept, no pixels.
    ex(KR, 2, 0, 0, -1); ex(KD, 2, 0, 0, 1);
    send(2, 3, 4, 0, 5, 6);
    wait_idle();

    // All three 1x1 at once: order 0,1,2, three cycles apiece.
    ex(KR, 0, 0, 0, -1); ex(KP, 1, 1, 1, 1); ex(KD, 0, 0, 0, 2);
    ex(KR, 1, 0, 0, 3);  ex(KP, 2, 2, 2, 1); ex(KD, 1, 0, 0, 2);
    ex(KR, 2, 0, 0, 3);  ex(KP, 3, 3, 3, 1); ex(KD, 2, 0, 0, 2);
    fork
      send(0, 1, 1, 1, 1, 1);
      send(1, 2, 2, 1, 1, 2);
      send(2, 3, 3, 1, 1, 3);
    join
    wait_idle();

    // 2x3 at (10,20), colour 5.
    ex(KR, 0, 0, 0, -1);
    ex(KP, 10, 20, 5, 1); ex(KP, 11, 20, 5, 2);
    ex(KP, 10, 21, 5, 3); ex(KP, 11, 21, 5, 4);
    ex(KP, 10, 22, 5, 5); ex(KP, 11, 22, 5, 6);
    ex(KD, 0, 0, 0, 7);
    send(0, 10, 20, 2, 3, 5);
    idle_check("hold1", 11, 22, 5);

    // Corner clipping: only (158,119) and (159,119) are written.
    ex(KR, 1, 0, 0, -1);
    ex(KP, 158, 119, 7, 1); ex(KP, 159, 119, 7, 2);
    ex(KD, 1, 0, 0, 9);
    send(1, 158, 119, 4, 2, 7);
    idle_check("hold_clip", 161, 120, 7);

    // Requester 0 re-requests during its own command; requester 1 goes next.
    ex(KR, 0, 0, 0, -1); ex(KP, 50, 60, 2, 1); ex(KP, 51, 60, 2, 2); ex(KD, 0, 0, 0, 3);
    ex(KR, 1, 0, 0, 4);  ex(KP, 70, 70, 3, 1); ex(KD, 1, 0, 0, 2);
    ex(KR, 0, 0, 0, 3);  ex(KP, 80, 90, 4, 1); ex(KD, 0, 0, 0, 2);
    send(0, 50, 60, 2, 1, 2);
    fork
      send(1, 70, 70, 1, 1, 3);
      send(0, 80, 90, 1, 1, 4);
    join
    wait_idle();

    // Leave ptr at 2, then abort a 4x4 from requester 2 at its third pixel.
    ex(KR, 1, 0, 0, -1); ex(KP, 9, 9, 6, 1); ex(KD, 1, 0, 0, 2);
    send(1, 9, 9, 1, 1, 6);
    wait_idle();
    ex(KR, 2, 0, 0, -1);
    ex(KP, 30, 40, 5, 1); ex(KP, 31, 40, 5, 2); ex(KP, 32, 40, 5, 3);
    send(2, 30, 40, 4, 4, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ctrl", int'({plot, busy, req_ready, done}), 0);
    chk("abort_xyc", int'({x, y, color}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ptr cleared by reset: requester 1 wins over 2.
    ex(KR, 1, 0, 0, -1); ex(KP, 5, 5, 1, 1); ex(KD, 1, 0, 0, 2);
    ex(KR, 2, 0, 0, 3);  ex(KP, 6, 6, 2, 1); ex(KD, 2, 0, 0, 2);
    fork
      send(1, 5, 5, 1, 1, 1);
      send(2, 6, 6, 1, 1, 2);
    join
    wait_idle();
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
